// File: rtl/mips32_array_reader_pkg.sv
// Shared defaults and FSM encoding for the length-prefixed array reader.
package mips32_array_reader_pkg;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_MAX_LEN = 256;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_LEN = 3'd1,
    ST_W_LEN  = 3'd2,
    ST_RD_EL  = 3'd3,
    ST_W_EL   = 3'd4,
    ST_PUSH   = 3'd5,
    ST_DIV    = 3'd6,
    ST_FIN    = 3'd7
  } state_t;
endpackage

// File: rtl/mips32_array_reader_seq_divider.sv
// Restoring shift-subtract divider: one quotient bit per cycle, DATA_W cycles after start.
module mips32_array_reader_seq_divider #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic              valid
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] rem_r;
  logic [DATA_W-1:0] quo_r;
  logic [DATA_W-1:0] dsr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              valid_r;
  logic [DATA_W:0]   shifted_s;
  logic              take_s;
  logic [DATA_W-1:0] diff_s;

  // The partial remainder is below the divisor, so the low DATA_W bits of the difference are exact
  assign shifted_s = {rem_r, quo_r[DATA_W-1]};
  assign take_s    = shifted_s >= {1'b0, dsr_r};
  assign diff_s    = shifted_s[DATA_W-1:0] - dsr_r;

  // Load on start, then shift one dividend bit into the remainder per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r   <= {DATA_W{1'b0}};
      quo_r   <= {DATA_W{1'b0}};
      dsr_r   <= {DATA_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      valid_r <= 1'b0;
    end else if (start) begin
      rem_r   <= {DATA_W{1'b0}};
      quo_r   <= dividend;
      dsr_r   <= divisor;
      cnt_r   <= CNT_W'(DATA_W);
      valid_r <= 1'b0;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      rem_r   <= take_s ? diff_s : shifted_s[DATA_W-1:0];
      quo_r   <= {quo_r[DATA_W-2:0], take_s};
      cnt_r   <= cnt_r - CNT_W'(1);
      valid_r <= (cnt_r == CNT_W'(1));
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign quotient = quo_r;
  assign valid    = valid_r;
endmodule

// File: rtl/mips32_array_reader.sv
// Reads N then N words from data memory, streams them out, and reports their sum and average.
module mips32_array_reader
  import mips32_array_reader_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len_addr,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] avg,
  output logic              err
);
  state_t            state_r;
  logic [ADDR_W-1:0] base_addr_r;
  logic [ADDR_W:0]   n_r;
  logic [ADDR_W:0]   i_r;
  logic [DATA_W-1:0] acc_r;
  logic              mem_rd_en_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] sum_r;
  logic [DATA_W-1:0] avg_r;
  logic              err_r;
  logic              div_start_r;
  logic [DATA_W-1:0] div_quot_s;
  logic              div_valid_s;
  logic [ADDR_W:0]   next_i_s;
  logic [ADDR_W-1:0] el_addr_s;

  assign next_i_s  = i_r + (ADDR_W + 1)'(1);
  assign el_addr_s = base_addr_r + next_i_s[ADDR_W-1:0];

  mips32_array_reader_seq_divider #(.DATA_W(DATA_W)) u_div (
    .clk      (clk1),
    .rst      (rst),
    .start    (div_start_r),
    .dividend (acc_r),
    .divisor  (DATA_W'(n_r)),
    .quotient (div_quot_s),
    .valid    (div_valid_s)
  );

  // Main FSM; every output is a register updated on the transition into the state that presents it
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      base_addr_r <= {ADDR_W{1'b0}};
      n_r         <= {(ADDR_W + 1){1'b0}};
      i_r         <= {(ADDR_W + 1){1'b0}};
      acc_r       <= {DATA_W{1'b0}};
      mem_rd_en_r <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      sum_r       <= {DATA_W{1'b0}};
      avg_r       <= {DATA_W{1'b0}};
      err_r       <= 1'b0;
      div_start_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            base_addr_r <= base_addr;
            mem_rd_en_r <= 1'b1;
            mem_addr_r  <= len_addr;
            busy_r      <= 1'b1;
            acc_r       <= {DATA_W{1'b0}};
            i_r         <= {(ADDR_W + 1){1'b0}};
            sum_r       <= {DATA_W{1'b0}};
            avg_r       <= {DATA_W{1'b0}};
            err_r       <= 1'b0;
            state_r     <= ST_RD_LEN;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_RD_LEN: begin
          mem_rd_en_r <= 1'b0;
          state_r     <= ST_W_LEN;
        end
        ST_W_LEN: begin
          if (mem_rdata == {DATA_W{1'b0}}) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_FIN;
          end else if (mem_rdata > DATA_W'(MAX_LEN)) begin
            err_r   <= 1'b1;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_FIN;
          end else begin
            n_r         <= mem_rdata[ADDR_W:0];
            mem_rd_en_r <= 1'b1;
            mem_addr_r  <= base_addr_r;
            state_r     <= ST_RD_EL;
          end
        end
        ST_RD_EL: begin
          mem_rd_en_r <= 1'b0;
          state_r     <= ST_W_EL;
        end
        ST_W_EL: begin
          out_data_r  <= mem_rdata;
          acc_r       <= acc_r + mem_rdata;
          out_valid_r <= 1'b1;
          state_r     <= ST_PUSH;
        end
        ST_PUSH: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            i_r         <= next_i_s;
            if (next_i_s == n_r) begin
              div_start_r <= 1'b1;
              state_r     <= ST_DIV;
            end else begin
              mem_rd_en_r <= 1'b1;
              mem_addr_r  <= el_addr_s;
              state_r     <= ST_RD_EL;
            end
          end else begin
            state_r <= ST_PUSH;
          end
        end
        ST_DIV: begin
          div_start_r <= 1'b0;
          if (div_valid_s) begin
            sum_r   <= acc_r;
            avg_r   <= div_quot_s;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_FIN;
          end else begin
            state_r <= ST_DIV;
          end
        end
        ST_FIN: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en = mem_rd_en_r;
  assign mem_addr  = mem_addr_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign sum       = sum_r;
  assign avg       = avg_r;
  assign err       = err_r;
endmodule

// File: tb/tb_mips32_array_reader.sv
// Directed bench for mips32_array_reader: memory model, beat scoreboard, result checks.
module tb_mips32_array_reader;
  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  len_addr = 10'd0;
  logic [9:0]  base_addr = 10'd0;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = 32'd0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic [31:0] avg;
  logic        err;

  logic [31:0] mem [0:1023];
  logic [31:0] exp_q [$];
  logic [9:0]  addr_log [$];
  logic [9:0]  exp_addr [5];
  int          n_tests = 0;
  int          n_fail = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data = 32'd0;

  always #5 clk1 = ~clk1;

  mips32_array_reader dut (
    .clk1      (clk1),
    .rst       (rst),
    .start     (start),
    .len_addr  (len_addr),
    .base_addr (base_addr),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .avg       (avg),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Synchronous-read memory: data one cycle after the strobe
  always @(posedge clk1) begin
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
      addr_log.push_back(mem_addr);
    end
  end

  // Beat monitor: pops the scoreboard on each handshake and checks stall stability
  always @(negedge clk1) begin
    if (rst) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, hold_data);
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("beat_data", out_data, exp_q.pop_front());
      end
      hold_pend <= out_valid && !out_ready;
      hold_data <= out_data;
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_start(input logic [9:0] la, input logic [9:0] ba);
    len_addr = la;
    base_addr = ba;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 2000 && !done; k++) tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_results(input string tag, input logic [31:0] s, input logic [31:0] a, input logic e);
    chk({tag, "_sum"}, sum, s);
    chk({tag, "_avg"}, avg, a);
    chk({tag, "_err"}, 32'(err), 32'(e));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_beats_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_t1();
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd30);
    exp_q.push_back(32'd40);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_sum"}, sum, 32'd0);
    chk({tag, "_avg"}, avg, 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[99] = 32'd4;
    mem[100] = 32'd5;
    mem[101] = 32'd20;
    mem[102] = 32'd30;
    mem[103] = 32'd40;
    out_ready = 1'b1;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Basic four-element run
    push_t1();
    do_start(10'd99, 10'd100);
    chk("t1_busy_rise", 32'(busy), 32'd1);
    wait_done("t1");
    check_results("t1", 32'd95, 32'd23, 1'b0);

    // Empty array
    mem[99] = 32'd0;
    do_start(10'd99, 10'd100);
    wait_done("t2");
    check_results("t2", 32'd0, 32'd0, 1'b0);

    // Back-pressure on the second beat
    mem[99] = 32'd4;
    out_ready = 1'b0;
    push_t1();
    do_start(10'd99, 10'd100);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 200 && !out_valid; k++) tick();
      chk("t3_valid_seen", 32'(out_valid), 32'd1);
      if (b == 1) begin
        for (int s = 0; s < 3; s++) begin
          chk("t3_stall_data", out_data, 32'd20);
          tick();
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    wait_done("t3");
    check_results("t3", 32'd95, 32'd23, 1'b0);
    out_ready = 1'b1;

    // Oversized length reports an error after a single read
    mem[99] = 32'd300;
    addr_log.delete();
    do_start(10'd99, 10'd100);
    wait_done("t4");
    check_results("t4", 32'd0, 32'd0, 1'b1);
    chk("t4_reads", 32'(addr_log.size()), 32'd1);

    // Element addresses wrap around the top of memory
    mem[500] = 32'd4;
    mem[1022] = 32'd1;
    mem[1023] = 32'd2;
    mem[0] = 32'd3;
    mem[1] = 32'd4;
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
    exp_addr = '{10'd500, 10'd1022, 10'd1023, 10'd0, 10'd1};
    addr_log.delete();
    do_start(10'd500, 10'd1022);
    wait_done("t5");
    check_results("t5", 32'd10, 32'd2, 1'b0);
    chk("t5_reads", 32'(addr_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < addr_log.size(); i++) chk("t5_addr", 32'(addr_log[i]), 32'(exp_addr[i]));

    // A second start while busy is ignored
    mem[99] = 32'd4;
    mem[200] = 32'd1;
    mem[201] = 32'd7;
    push_t1();
    do_start(10'd99, 10'd100);
    repeat (3) tick();
    do_start(10'd200, 10'd201);
    wait_done("t6");
    check_results("t6", 32'd95, 32'd23, 1'b0);

    // Sum wraps modulo 2^32
    mem[600] = 32'd2;
    mem[601] = 32'hFFFF_FFFF;
    mem[602] = 32'd2;
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'd2);
    do_start(10'd600, 10'd601);
    wait_done("t7");
    check_results("t7", 32'd1, 32'd0, 1'b0);

    // Reset while a beat is pending, then a clean run
    out_ready = 1'b0;
    push_t1();
    do_start(10'd99, 10'd100);
    for (int k = 0; k < 200 && !out_valid; k++) tick();
    chk("t8_valid_seen", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("t8_rst");
    exp_q.delete();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    push_t1();
    do_start(10'd99, 10'd100);
    wait_done("t8");
    check_results("t8", 32'd95, 32'd23, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
